// File: rtl/pwr_seq_pkg.sv
// Shared state codes, defaults and per-state output decode for the power sequencer.
package pwr_seq_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned FLUSH_W       = 2;
  localparam int unsigned STEP_CYC_DEF  = 4;
  localparam int unsigned EFUSE_TMO_DEF = 64;
  localparam int unsigned FLUSH_LEN     = 2;

  localparam logic [STATE_W-1:0] S_EFUSE  = 3'd0;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd1;
  localparam logic [STATE_W-1:0] S_UP_RST = 3'd2;
  localparam logic [STATE_W-1:0] S_UP_CLK = 3'd3;
  localparam logic [STATE_W-1:0] S_RUN    = 3'd4;
  localparam logic [STATE_W-1:0] S_DN_CLK = 3'd5;
  localparam logic [STATE_W-1:0] S_DN_RST = 3'd6;

  typedef struct packed {
    logic efuse_load_state;
    logic shut_rstn;
    logic afe_clk_en;
    logic slot_clk_en;
    logic data_clk_en;
    logic timer_clk_en;
    logic seq_busy;
  } seq_out_t;

  // Static CRGU controls for each state; pmu_fifo_rstn is handled separately.
  function automatic seq_out_t state_outs(input logic [STATE_W-1:0] st);
    seq_out_t o;
    o = '0;
    case (st)
      S_EFUSE: begin
        o.efuse_load_state = 1'b1;
        o.seq_busy         = 1'b1;
      end
      S_UP_RST: begin
        o.shut_rstn = 1'b1;
        o.seq_busy  = 1'b1;
      end
      S_UP_CLK, S_DN_CLK: begin
        o.shut_rstn  = 1'b1;
        o.afe_clk_en = 1'b1;
        o.seq_busy   = 1'b1;
      end
      S_RUN: begin
        o.shut_rstn    = 1'b1;
        o.afe_clk_en   = 1'b1;
        o.slot_clk_en  = 1'b1;
        o.data_clk_en  = 1'b1;
        o.timer_clk_en = 1'b1;
      end
      S_DN_RST: o.seq_busy = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pwr_seq_step_timer.sv
// 8-bit loadable down counter that saturates at zero; done_c flags zero.
module pwr_seq_step_timer
  import pwr_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 8'd63
) (
  input  logic             clk_32k,
  input  logic             rst_32k,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_32k) begin
    if (rst_32k) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Always-on power sequencer: efuse load, staged reset/clock bring-up and tear-down, FIFO flush.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned STEP_CYC  = STEP_CYC_DEF,
  parameter int unsigned EFUSE_TMO = EFUSE_TMO_DEF
) (
  input  logic               clk_32k,
  input  logic               rst_32k,
  input  logic               top_start,
  input  logic               efuse_done,
  input  logic               fifo_flush_req,
  output logic               efuse_load_state,
  output logic               shut_rstn,
  output logic               afe_clk_en,
  output logic               slot_clk_en,
  output logic               data_clk_en,
  output logic               timer_clk_en,
  output logic               pmu_fifo_rstn,
  output logic               seq_busy,
  output logic               efuse_err,
  output logic [STATE_W-1:0] seq_state
);

  logic [STATE_W-1:0] state_q, state_d;
  seq_out_t           outs_q, outs_d;
  logic               efuse_err_q, efuse_err_d;
  logic               pmu_fifo_rstn_q, pmu_fifo_rstn_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;

  pwr_seq_step_timer #(
    .RST_VAL (CNT_W'(EFUSE_TMO - 1))
  ) u_step_timer (
    .clk_32k  (clk_32k),
    .rst_32k  (rst_32k),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  // Next state, sticky error, flush pulse and registered output decode.
  always_comb begin
    state_d         = state_q;
    efuse_err_d     = efuse_err_q;
    flush_cnt_d     = '0;
    pmu_fifo_rstn_d = 1'b0;

    case (state_q)
      S_EFUSE: begin
        if (efuse_done) begin
          state_d = S_IDLE;
        end else if (tmr_done) begin
          state_d     = S_IDLE;
          efuse_err_d = 1'b1;
        end
      end
      S_IDLE:   if (top_start) state_d = S_UP_RST;
      S_UP_RST: begin
        if (!top_start)    state_d = S_DN_RST;
        else if (tmr_done) state_d = S_UP_CLK;
      end
      S_UP_CLK: begin
        if (!top_start)    state_d = S_DN_RST;
        else if (tmr_done) state_d = S_RUN;
      end
      S_RUN:    if (!top_start) state_d = S_DN_CLK;
      S_DN_CLK: if (tmr_done) state_d = S_DN_RST;
      S_DN_RST: if (tmr_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Every state change restarts the step count.
    tmr_load = (state_d != state_q);
    tmr_val  = (state_d == S_EFUSE) ? CNT_W'(EFUSE_TMO - 1) : CNT_W'(STEP_CYC - 1);

    // Flush counter only lives while staying in RUN; leaving RUN drops it.
    if (state_d == S_RUN) begin
      if (state_q == S_RUN) begin
        if (flush_cnt_q != '0) begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end else if (fifo_flush_req) begin
          flush_cnt_d = FLUSH_W'(FLUSH_LEN);
        end
      end
      pmu_fifo_rstn_d = (flush_cnt_d == '0);
    end

    outs_d = state_outs(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_32k) begin
    if (rst_32k) begin
      state_q         <= S_EFUSE;
      outs_q          <= state_outs(S_EFUSE);
      efuse_err_q     <= 1'b0;
      pmu_fifo_rstn_q <= 1'b0;
      flush_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      outs_q          <= outs_d;
      efuse_err_q     <= efuse_err_d;
      pmu_fifo_rstn_q <= pmu_fifo_rstn_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign efuse_load_state = outs_q.efuse_load_state;
  assign shut_rstn        = outs_q.shut_rstn;
  assign afe_clk_en       = outs_q.afe_clk_en;
  assign slot_clk_en      = outs_q.slot_clk_en;
  assign data_clk_en      = outs_q.data_clk_en;
  assign timer_clk_en     = outs_q.timer_clk_en;
  assign seq_busy         = outs_q.seq_busy;
  assign pmu_fifo_rstn    = pmu_fifo_rstn_q;
  assign efuse_err        = efuse_err_q;
  assign seq_state        = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with STEP_CYC=4, EFUSE_TMO=64.
module tb_pwr_seq_ctrl;

  localparam logic [2:0] T_EFUSE  = 3'd0;
  localparam logic [2:0] T_IDLE   = 3'd1;
  localparam logic [2:0] T_UP_RST = 3'd2;
  localparam logic [2:0] T_UP_CLK = 3'd3;
  localparam logic [2:0] T_RUN    = 3'd4;
  localparam logic [2:0] T_DN_CLK = 3'd5;
  localparam logic [2:0] T_DN_RST = 3'd6;

  logic       clk_32k = 1'b0;
  logic       rst_32k = 1'b0;
  logic       top_start = 1'b0;
  logic       efuse_done = 1'b0;
  logic       fifo_flush_req = 1'b0;
  logic       efuse_load_state, shut_rstn, afe_clk_en, slot_clk_en;
  logic       data_clk_en, timer_clk_en, pmu_fifo_rstn, seq_busy, efuse_err;
  logic [2:0] seq_state;

  int tests = 0;
  int fails = 0;

  pwr_seq_ctrl #(.STEP_CYC(4), .EFUSE_TMO(64)) dut (
    .clk_32k          (clk_32k),
    .rst_32k          (rst_32k),
    .top_start        (top_start),
    .efuse_done       (efuse_done),
    .fifo_flush_req   (fifo_flush_req),
    .efuse_load_state (efuse_load_state),
    .shut_rstn        (shut_rstn),
    .afe_clk_en       (afe_clk_en),
    .slot_clk_en      (slot_clk_en),
    .data_clk_en      (data_clk_en),
    .timer_clk_en     (timer_clk_en),
    .pmu_fifo_rstn    (pmu_fifo_rstn),
    .seq_busy         (seq_busy),
    .efuse_err        (efuse_err),
    .seq_state        (seq_state)
  );

  always #5 clk_32k = ~clk_32k;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_32k);
      #1;
    end
  endtask

  // Expected {efuse_load, shut_rstn, afe, slot, data, timer, pmu_fifo_rstn, busy, err}.
  function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic pmu, input logic err);
    case (st)
      T_EFUSE:  return {7'b1000000, 1'b1, err};
      T_IDLE:   return {7'b0000000, 1'b0, err};
      T_UP_RST: return {7'b0100000, 1'b1, err};
      T_UP_CLK: return {7'b0110000, 1'b1, err};
      T_RUN:    return {6'b011111, pmu, 1'b0, err};
      T_DN_CLK: return {7'b0110000, 1'b1, err};
      T_DN_RST: return {7'b0000000, 1'b1, err};
      default:  return 9'h1ff;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] st, input logic pmu, input logic err);
    check(tag, {seq_state, efuse_load_state, shut_rstn, afe_clk_en, slot_clk_en, data_clk_en,
                timer_clk_en, pmu_fifo_rstn, seq_busy, efuse_err},
          {st, exp_vec(st, pmu, err)});
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
    int n = 0;
    while (seq_state !== st && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(tag, {9'd0, seq_state}, {9'd0, st});
  endtask

  initial begin
    // Reset, then efuse_done in cycle 10.
    rst_32k = 1'b1;
    tick(2);
    check_st("reset", T_EFUSE, 1'b0, 1'b0);
    rst_32k = 1'b0;
    tick(10);
    check_st("efuse_cyc10", T_EFUSE, 1'b0, 1'b0);
    efuse_done = 1'b1;
    tick(1);
    efuse_done = 1'b0;
    check_st("efuse_ok_idle", T_IDLE, 1'b0, 1'b0);

    // Efuse timeout: 64 cycles in S_EFUSE, then sticky error.
    rst_32k = 1'b1;
    tick(1);
    rst_32k = 1'b0;
    tick(63);
    check_st("tmo_cyc63", T_EFUSE, 1'b0, 1'b0);
    tick(1);
    check_st("tmo_idle", T_IDLE, 1'b0, 1'b1);
    tick(5);
    check_st("err_held", T_IDLE, 1'b0, 1'b1);

    // Reset clears error; efuse_done on the timeout cycle is success.
    rst_32k = 1'b1;
    tick(1);
    rst_32k = 1'b0;
    check_st("err_cleared", T_EFUSE, 1'b0, 1'b0);
    tick(63);
    efuse_done = 1'b1;
    tick(1);
    efuse_done = 1'b0;
    check_st("tmo_tie_ok", T_IDLE, 1'b0, 1'b0);

    // Power-up sequence.
    top_start = 1'b1;
    tick(1);
    check_st("up_rst_c1", T_UP_RST, 1'b0, 1'b0);
    tick(3);
    check_st("up_rst_c4", T_UP_RST, 1'b0, 1'b0);
    tick(1);
    check_st("up_clk_c5", T_UP_CLK, 1'b0, 1'b0);
    tick(3);
    check_st("up_clk_c8", T_UP_CLK, 1'b0, 1'b0);
    tick(1);
    check_st("run_c9", T_RUN, 1'b1, 1'b0);

    // Flush with a repeated request one cycle later.
    fifo_flush_req = 1'b1;
    tick(1);
    check_st("flush_lo1", T_RUN, 1'b0, 1'b0);
    tick(1);
    fifo_flush_req = 1'b0;
    check_st("flush_lo2", T_RUN, 1'b0, 1'b0);
    tick(1);
    check_st("flush_hi1", T_RUN, 1'b1, 1'b0);
    tick(1);
    check_st("flush_hi2", T_RUN, 1'b1, 1'b0);

    // Power-down sequence.
    top_start = 1'b0;
    tick(1);
    check_st("dn_clk_c1", T_DN_CLK, 1'b0, 1'b0);
    tick(3);
    check_st("dn_clk_c4", T_DN_CLK, 1'b0, 1'b0);
    tick(1);
    check_st("dn_rst_c5", T_DN_RST, 1'b0, 1'b0);
    tick(3);
    check_st("dn_rst_c8", T_DN_RST, 1'b0, 1'b0);
    tick(1);
    check_st("dn_idle_c9", T_IDLE, 1'b0, 1'b0);

    // Abort from S_UP_CLK, re-request during S_DN_RST.
    top_start = 1'b1;
    tick(1);
    check_st("ab_up_rst", T_UP_RST, 1'b0, 1'b0);
    tick(4);
    check_st("ab_up_clk", T_UP_CLK, 1'b0, 1'b0);
    tick(1);
    top_start = 1'b0;
    tick(1);
    check_st("ab_dn_rst", T_DN_RST, 1'b0, 1'b0);
    top_start = 1'b1;
    tick(3);
    check_st("ab_dn_rst_c4", T_DN_RST, 1'b0, 1'b0);
    tick(1);
    check_st("ab_idle", T_IDLE, 1'b0, 1'b0);
    tick(1);
    check_st("ab_restart", T_UP_RST, 1'b0, 1'b0);
    tick(8);
    check_st("ab_run", T_RUN, 1'b1, 1'b0);

    // Leave S_RUN mid-flush; down states not aborted by top_start.
    fifo_flush_req = 1'b1;
    tick(1);
    fifo_flush_req = 1'b0;
    top_start = 1'b0;
    check_st("mid_flush", T_RUN, 1'b0, 1'b0);
    tick(1);
    check_st("exit_flush", T_DN_CLK, 1'b0, 1'b0);
    top_start = 1'b1;
    fifo_flush_req = 1'b1;
    tick(1);
    fifo_flush_req = 1'b0;
    check_st("dn_no_abort", T_DN_CLK, 1'b0, 1'b0);
    wait_state("rerun", T_RUN, 40);
    check_st("rerun_pmu", T_RUN, 1'b1, 1'b0);

    // Reset during a flush.
    fifo_flush_req = 1'b1;
    tick(1);
    fifo_flush_req = 1'b0;
    check_st("flush_pre_rst", T_RUN, 1'b0, 1'b0);
    rst_32k = 1'b1;
    tick(1);
    check_st("rst_mid_flush", T_EFUSE, 1'b0, 1'b0);
    rst_32k = 1'b0;
    top_start = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
